core_sequencer: RTL and testbench
=================================

Name: core_sequencer

Overview:
- Multi-cycle controller that sequences the single-issue integer datapath: FETCH, WAIT, DECODE, EXECUTE, WRITEBACK.
- Fetches each instruction over a req/valid handshake and holds it in an instruction register that feeds the combinational control unit.
- Gates the control unit's reg_write into a one-cycle register-file write strobe, then advances the PC.
- Halts permanently on an unsupported opcode or an instruction-memory timeout.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 16, maximum WAIT cycles before a timeout halt (must be >=1).
- CNT_W, 5, width of the WAIT timeout counter (2^CNT_W > TIMEOUT).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request strobe, one cycle.
- imem_addr  out  32  fetch address; equals pc.
- imem_rdata  in  32  fetched instruction word.
- imem_valid  in  1  imem_rdata valid; sampled only in WAIT.
- instr  out  32  instruction register, drives the control unit's instruction input.
- ir_valid  out  1  high in DECODE, EXECUTE and WRITEBACK.
- cu_reg_write  in  1  reg_write from the control unit.
- stall  in  1  holds EXECUTE while high.
- rf_we  out  1  register-file write strobe.
- pc  out  32  current program counter.
- halt  out  1  sticky halted flag.
- halt_cause  out  2  0 none, 1 illegal opcode, 2 imem timeout.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - state=FETCH, pc=RESET_PC, instr=32'h0000_0013 (NOP).
  - imem_req=0, rf_we=0, ir_valid=0, halt=0, halt_cause=0, wait counter=0.
  - Reset overrides every state, including WAIT and HALT.
- FETCH: imem_req=1 and imem_addr=pc for exactly one cycle; next state WAIT; wait counter cleared.
- WAIT:
  - imem_req=0.
  - If imem_valid=1: instr<=imem_rdata, next state DECODE.
  - Else: counter increments; when counter reaches TIMEOUT with imem_valid still 0, next state HALT with halt_cause=2.
  - imem_valid arriving in the same cycle the counter reaches TIMEOUT wins; the instruction is accepted and no halt occurs.
- DECODE (1 cycle): check instr[6:0].
  - 7'b0010011 (OP-IMM) or 7'b0110011 (OP): next state EXECUTE.
  - Any other value: next state HALT, halt_cause=1; no write and no PC change.
- EXECUTE: stays in EXECUTE while stall=1; otherwise next state WRITEBACK.
- WRITEBACK (1 cycle):
  - rf_we = cu_reg_write AND (instr[11:7] != 0); asserted only in this state.
  - pc<=pc+4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
  - Next state FETCH.
- HALT: absorbing until rst. halt=1; imem_req=0, rf_we=0, ir_valid=0; instr and pc frozen. halt_cause is written only on entry to HALT.
- imem_valid outside WAIT is ignored; a late response after a timeout is ignored.
- Minimum latency with imem_valid in the first WAIT cycle: 5 cycles/instruction, with imem_req asserted every 5th cycle.
- All outputs are registered except imem_addr (=pc), rf_we (state- and input-decoded) and ir_valid (state-decoded).

Optional Feature:
- Macro: CORE_SEQUENCER_INSTRET_EN.
- Defined:
  - Adds output port instret (32 bits), reset to 0, incremented by 1 in each WRITEBACK cycle; wraps 32'hFFFF_FFFF to 0.
  - Adds output port stall_cycles (32 bits), reset to 0, incremented on each EXECUTE cycle with stall=1.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset, then instr 32'h4083D313 (srai x6,x7,8) with imem_valid in the first WAIT cycle, cu_reg_write=1 -> imem_req at cycles 0 and 5; rf_we=1 exactly at cycle 4; pc 0->4.
- imem_valid delayed 3 WAIT cycles -> DECODE entered on the cycle after valid; period is 8 cycles; no halt.
- imem_valid never asserted, TIMEOUT=16 -> halt=1 and halt_cause=2 after 16 WAIT cycles; pc unchanged; further imem_valid ignored.
- Fetch 32'h0000_0073 (SYSTEM opcode) -> HALT after DECODE with halt_cause=1; rf_we never asserted; pc unchanged.
- Instr with rd=0 (32'h00000013) and cu_reg_write=1 -> rf_we stays 0; pc still +4. stall=1 for 3 cycles in EXECUTE -> WRITEBACK delayed by 3 cycles.
- rst pulsed mid-WAIT, and separately while in HALT -> next cycle state=FETCH, pc=RESET_PC, halt=0, halt_cause=0, instr=32'h00000013; with CORE_SEQUENCER_INSTRET_EN, instret=0.

Source files
------------

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the single-issue integer datapath.
// Optional retired-instruction and stall counters: define CORE_SEQUENCER_INSTRET_EN.
module core_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16,
  parameter int          CNT_W    = 5
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] instr,
  output logic        ir_valid,
  input  logic        cu_reg_write,
  input  logic        stall,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic        halt,
`ifdef CORE_SEQUENCER_INSTRET_EN
  output logic [31:0] instret,
  output logic [31:0] stall_cycles,
`endif
  output logic [1:0]  halt_cause
);

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [6:0]  OP_IMM  = 7'b0010011;
  localparam logic [6:0]  OP_REG  = 7'b0110011;
  localparam logic [1:0]  C_ILLEG = 2'd1;
  localparam logic [1:0]  C_TMO   = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH, S_WAIT, S_DECODE, S_EXEC, S_WB, S_HALT
  } state_t;

  state_t             state_q;
  logic [31:0]        pc_q, instr_q;
  logic               req_q, halt_q;
  logic [1:0]         cause_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        pc_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               legal_d;

  assign pc_d    = pc_q + 32'd4;
  assign cnt_d   = cnt_q + CNT_W'(1);
  assign legal_d = (instr_q[6:0] == OP_IMM) || (instr_q[6:0] == OP_REG);

  // req_q is registered, so the FETCH right after reset spends one cycle
  // raising it; every later FETCH is entered with req_q already set.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      req_q   <= 1'b0;
      halt_q  <= 1'b0;
      cause_q <= 2'd0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (req_q) begin
            req_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_WAIT;
          end else begin
            req_q   <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_valid) begin
            instr_q <= imem_rdata;
            state_q <= S_DECODE;
          end else begin
            cnt_q <= cnt_d;
            if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
              halt_q  <= 1'b1;
              cause_q <= C_TMO;
              state_q <= S_HALT;
            end
          end
        end
        S_DECODE: begin
          if (legal_d) begin
            state_q <= S_EXEC;
          end else begin
            halt_q  <= 1'b1;
            cause_q <= C_ILLEG;
            state_q <= S_HALT;
          end
        end
        S_EXEC: begin
          if (!stall) state_q <= S_WB;
        end
        S_WB: begin
          pc_q    <= pc_d;
          req_q   <= 1'b1;
          state_q <= S_FETCH;
        end
        S_HALT: ;
        default: state_q <= S_HALT;
      endcase
    end
  end

`ifdef CORE_SEQUENCER_INSTRET_EN
  logic [31:0] instret_q, stall_cycles_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      instret_q      <= '0;
      stall_cycles_q <= '0;
    end else begin
      if (state_q == S_WB)           instret_q      <= instret_q + 32'd1;
      if (state_q == S_EXEC && stall) stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign instret      = instret_q;
  assign stall_cycles = stall_cycles_q;
`endif

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign instr      = instr_q;
  assign pc         = pc_q;
  assign halt       = halt_q;
  assign halt_cause = cause_q;
  assign ir_valid   = (state_q == S_DECODE) || (state_q == S_EXEC) || (state_q == S_WB);
  assign rf_we      = (state_q == S_WB) && cu_reg_write && (instr_q[11:7] != 5'd0);

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: a per-cycle vector table plus hand-built
// timeout, timeout-boundary and reset sequences.
module tb_core_sequencer;

  logic        clk, rst;
  logic        imem_req, imem_valid, ir_valid, cu_reg_write, stall, rf_we, halt;
  logic [31:0] imem_addr, imem_rdata, instr, pc;
  logic [1:0]  halt_cause;
`ifdef CORE_SEQUENCER_INSTRET_EN
  logic [31:0] instret, stall_cycles;
`endif

  core_sequencer dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_valid(imem_valid), .instr(instr), .ir_valid(ir_valid),
    .cu_reg_write(cu_reg_write), .stall(stall), .rf_we(rf_we), .pc(pc),
    .halt(halt),
`ifdef CORE_SEQUENCER_INSTRET_EN
    .instret(instret), .stall_cycles(stall_cycles),
`endif
    .halt_cause(halt_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] rd;
    logic        cu;
    logic        st;
    logic        req;
    logic        we;
    logic        irv;
    logic        hlt;
    logic [1:0]  cause;
    logic [31:0] pc;
    logic [31:0] ins;
  } vec_t;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] SRAI = 32'h4083_D313;
  localparam logic [31:0] ADD  = 32'h00B5_0533;
  localparam logic [31:0] SYS  = 32'h0000_0073;

  int n_chk = 0;
  int n_fail = 0;
  vec_t tbl[$];

  function automatic vec_t mkv(logic v, logic [31:0] rd, logic cu, logic st, logic req,
                               logic we, logic irv, logic hlt, logic [1:0] cause,
                               logic [31:0] pcv, logic [31:0] ins);
    vec_t t;
    t.v = v; t.rd = rd; t.cu = cu; t.st = st; t.req = req; t.we = we;
    t.irv = irv; t.hlt = hlt; t.cause = cause; t.pc = pcv; t.ins = ins;
    return t;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(string tag, vec_t t);
    imem_valid = t.v; imem_rdata = t.rd; cu_reg_write = t.cu; stall = t.st;
    #1;
    chk({tag, " imem_req"},   32'(imem_req),   32'(t.req));
    chk({tag, " rf_we"},      32'(rf_we),      32'(t.we));
    chk({tag, " ir_valid"},   32'(ir_valid),   32'(t.irv));
    chk({tag, " halt"},       32'(halt),       32'(t.hlt));
    chk({tag, " halt_cause"}, 32'(halt_cause), 32'(t.cause));
    chk({tag, " pc"},         pc,              t.pc);
    chk({tag, " imem_addr"},  imem_addr,       t.pc);
    chk({tag, " instr"},      instr,           t.ins);
    cyc();
  endtask

  task automatic do_reset(string tag);
    rst = 1'b1; imem_valid = 1'b1; imem_rdata = SYS; stall = 1'b0; cu_reg_write = 1'b1;
    cyc();
    rst = 1'b0; imem_valid = 1'b0;
    #1;
    chk({tag, " rst imem_req"},   32'(imem_req),   32'd0);
    chk({tag, " rst rf_we"},      32'(rf_we),      32'd0);
    chk({tag, " rst ir_valid"},   32'(ir_valid),   32'd0);
    chk({tag, " rst halt"},       32'(halt),       32'd0);
    chk({tag, " rst halt_cause"}, 32'(halt_cause), 32'd0);
    chk({tag, " rst pc"},         pc,              32'd0);
    chk({tag, " rst instr"},      instr,           NOP);
`ifdef CORE_SEQUENCER_INSTRET_EN
    chk({tag, " rst instret"},      instret,      32'd0);
    chk({tag, " rst stall_cycles"}, stall_cycles, 32'd0);
`endif
  endtask

  initial begin
    rst = 1'b1; imem_valid = 1'b0; imem_rdata = '0; cu_reg_write = 1'b0; stall = 1'b0;
    cyc();
    do_reset("init");

    //            v  rd    cu st req we irv hlt cause pc     instr
    tbl.push_back(mkv(0, 0,    1, 0, 0, 0, 0, 0, 0, 32'd0,  NOP));   // FETCH (raise req)
    tbl.push_back(mkv(0, 0,    1, 0, 1, 0, 0, 0, 0, 32'd0,  NOP));   // FETCH, cycle 0
    tbl.push_back(mkv(1, SRAI, 1, 0, 0, 0, 0, 0, 0, 32'd0,  NOP));   // WAIT, valid at once
    tbl.push_back(mkv(0, 0,    1, 1, 0, 0, 1, 0, 0, 32'd0,  SRAI));  // DECODE, stall ignored
    tbl.push_back(mkv(0, 0,    1, 0, 0, 0, 1, 0, 0, 32'd0,  SRAI));  // EXECUTE
    tbl.push_back(mkv(0, 0,    1, 0, 0, 1, 1, 0, 0, 32'd0,  SRAI));  // WRITEBACK, cycle 4
    tbl.push_back(mkv(1, ADD,  1, 0, 1, 0, 0, 0, 0, 32'd4,  SRAI));  // FETCH cycle 5, valid ignored
    tbl.push_back(mkv(0, 0,    1, 0, 0, 0, 0, 0, 0, 32'd4,  SRAI));  // WAIT 1
    tbl.push_back(mkv(0, 0,    1, 0, 0, 0, 0, 0, 0, 32'd4,  SRAI));  // WAIT 2
    tbl.push_back(mkv(0, 0,    1, 0, 0, 0, 0, 0, 0, 32'd4,  SRAI));  // WAIT 3
    tbl.push_back(mkv(1, ADD,  1, 0, 0, 0, 0, 0, 0, 32'd4,  SRAI));  // WAIT 4, valid
    tbl.push_back(mkv(0, 0,    1, 0, 0, 0, 1, 0, 0, 32'd4,  ADD));   // DECODE
    tbl.push_back(mkv(0, 0,    1, 0, 0, 0, 1, 0, 0, 32'd4,  ADD));   // EXECUTE
    tbl.push_back(mkv(0, 0,    1, 0, 0, 1, 1, 0, 0, 32'd4,  ADD));   // WRITEBACK
    tbl.push_back(mkv(0, 0,    1, 0, 1, 0, 0, 0, 0, 32'd8,  ADD));   // FETCH, 8 cycles later
    tbl.push_back(mkv(1, NOP,  1, 0, 0, 0, 0, 0, 0, 32'd8,  ADD));   // WAIT, valid
    tbl.push_back(mkv(0, 0,    1, 0, 0, 0, 1, 0, 0, 32'd8,  NOP));   // DECODE
    tbl.push_back(mkv(0, 0,    1, 1, 0, 0, 1, 0, 0, 32'd8,  NOP));   // EXECUTE stall 1
    tbl.push_back(mkv(0, 0,    1, 1, 0, 0, 1, 0, 0, 32'd8,  NOP));   // EXECUTE stall 2
    tbl.push_back(mkv(0, 0,    1, 1, 0, 0, 1, 0, 0, 32'd8,  NOP));   // EXECUTE stall 3
    tbl.push_back(mkv(0, 0,    1, 0, 0, 0, 1, 0, 0, 32'd8,  NOP));   // EXECUTE release
    tbl.push_back(mkv(0, 0,    1, 0, 0, 0, 1, 0, 0, 32'd8,  NOP));   // WRITEBACK, rd=0 -> no write
    tbl.push_back(mkv(0, 0,    1, 0, 1, 0, 0, 0, 0, 32'd12, NOP));   // FETCH
    tbl.push_back(mkv(1, SYS,  1, 0, 0, 0, 0, 0, 0, 32'd12, NOP));   // WAIT, SYSTEM opcode
    tbl.push_back(mkv(0, 0,    1, 0, 0, 0, 1, 0, 0, 32'd12, SYS));   // DECODE -> illegal
    tbl.push_back(mkv(0, 0,    1, 0, 0, 0, 0, 1, 1, 32'd12, SYS));   // HALT cause 1
    tbl.push_back(mkv(1, ADD,  1, 1, 0, 0, 0, 1, 1, 32'd12, SYS));   // HALT, inputs ignored

    for (int i = 0; i < tbl.size(); i++) begin
`ifdef CORE_SEQUENCER_INSTRET_EN
      if (i == 25) begin
        chk("tbl instret", instret, 32'd3);
        chk("tbl stall_cycles", stall_cycles, 32'd3);
      end
`endif
      apply($sformatf("tbl[%0d]", i), tbl[i]);
    end

    do_reset("in_halt");

    // Timeout: 16 WAIT cycles without valid, then a sticky halt that ignores late responses.
    apply("tmo fetch0", mkv(0, 0, 1, 0, 0, 0, 0, 0, 0, 32'd0, NOP));
    apply("tmo fetch1", mkv(0, 0, 1, 0, 1, 0, 0, 0, 0, 32'd0, NOP));
    for (int k = 1; k <= 16; k++)
      apply($sformatf("tmo wait%0d", k), mkv(0, 0, 1, 0, 0, 0, 0, 0, 0, 32'd0, NOP));
    for (int k = 0; k < 3; k++)
      apply($sformatf("tmo halt%0d", k), mkv(1, ADD, 1, 0, 0, 0, 0, 1, 2, 32'd0, NOP));

    do_reset("after_tmo");

    // Valid arriving on the 16th WAIT cycle is accepted; cu_reg_write=0 suppresses the write.
    apply("bnd fetch0", mkv(0, 0, 1, 0, 0, 0, 0, 0, 0, 32'd0, NOP));
    apply("bnd fetch1", mkv(0, 0, 1, 0, 1, 0, 0, 0, 0, 32'd0, NOP));
    for (int k = 1; k <= 15; k++)
      apply($sformatf("bnd wait%0d", k), mkv(0, 0, 1, 0, 0, 0, 0, 0, 0, 32'd0, NOP));
    apply("bnd wait16", mkv(1, ADD, 1, 0, 0, 0, 0, 0, 0, 32'd0, NOP));
    apply("bnd decode", mkv(0, 0,   1, 0, 0, 0, 1, 0, 0, 32'd0, ADD));
    apply("bnd exec",   mkv(0, 0,   1, 0, 0, 0, 1, 0, 0, 32'd0, ADD));
    apply("bnd wb",     mkv(0, 0,   0, 0, 0, 0, 1, 0, 0, 32'd0, ADD));
    apply("bnd fetch",  mkv(0, 0,   1, 0, 1, 0, 0, 0, 0, 32'd4, ADD));
    apply("bnd wait_a", mkv(0, 0,   1, 0, 0, 0, 0, 0, 0, 32'd4, ADD));
    apply("bnd wait_b", mkv(0, 0,   1, 0, 0, 0, 0, 0, 0, 32'd4, ADD));

    do_reset("mid_wait");
    apply("post fetch0", mkv(0, 0, 1, 0, 0, 0, 0, 0, 0, 32'd0, NOP));
    apply("post fetch1", mkv(0, 0, 1, 0, 1, 0, 0, 0, 0, 32'd0, NOP));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
